// File: rtl/sram_uart_dump_pkg.sv
// Shared definitions for the SRAM-to-UART dump path: FSM state encoding and
// the default baud divider for a 50 MHz clock at 115200 baud.
package sram_uart_dump_pkg;

  localparam int BAUD_DIV_50M = 434;

  typedef enum logic [2:0] {
    S_DUMP_IDLE,
    S_DUMP_ADDR,
    S_DUMP_WAIT1,
    S_DUMP_LATCH,
    S_DUMP_SEND_HI,
    S_DUMP_SEND_LO,
    S_DUMP_DONE
  } dump_state_type;

endpackage

// File: rtl/sram_uart_dump_uart_tx_byte.sv
// 8N1 byte transmitter with a registered serial output. A new frame may be
// started in the same cycle tx_done pulses, giving back-to-back frames.
module uart_tx_byte
  import sram_uart_dump_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_50M
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       UART_TX_O,
  output logic       tx_busy,
  output logic       tx_done
);

  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift_reg;
  logic        bit_end;

  assign bit_end = tx_busy && (baud_cnt == 16'(BAUD_DIV - 1));
  assign tx_done = bit_end && (bit_cnt == 4'd9);

  // shift_reg carries the data bits followed by the stop bit, LSB shifted out first
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      UART_TX_O <= 1'b1;
      tx_busy   <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '1;
    end else if (tx_start && (!tx_busy || tx_done)) begin
      UART_TX_O <= 1'b0;
      tx_busy   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= {1'b1, tx_data};
    end else if (tx_done) begin
      UART_TX_O <= 1'b1;
      tx_busy   <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else if (bit_end) begin
      UART_TX_O <= shift_reg[0];
      shift_reg <= {1'b1, shift_reg[8:1]};
      baud_cnt  <= '0;
      bit_cnt   <= bit_cnt + 4'd1;
    end else if (tx_busy) begin
      baud_cnt  <= baud_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sram_uart_dump.sv
// Streams a block of 16-bit SRAM words out of the UART, high byte first.
// Holds the dump FSM plus the address, word-index and data registers.
module sram_uart_dump
  import sram_uart_dump_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD_DIV = BAUD_DIV_50M,
  parameter int ADDR_W   = 18
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [ADDR_W-1:0] Word_count,
  output logic [ADDR_W-1:0] SRAM_address,
  input  logic [15:0]       SRAM_read_data,
  output logic              SRAM_we_n,
  output logic              UART_TX_O,
  output logic              Busy,
  output logic              Done
);

  if (BAUD_DIV < 2 || BAUD_DIV > 65535 || CLK_FREQ < 2 * BAUD_DIV) begin : g_bad_params
    $error("sram_uart_dump: illegal BAUD_DIV / CLK_FREQ combination");
  end

  dump_state_type    state, next_state;
  logic [ADDR_W-1:0] addr_reg, word_index, word_count_reg, word_next;
  logic [15:0]       word_reg;
  logic              tx_start, tx_busy, tx_done;
  logic [7:0]        tx_data;

  assign word_next    = word_index + ADDR_W'(1);
  assign SRAM_address = addr_reg;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = (state != S_DUMP_IDLE);
  assign Done         = (state == S_DUMP_DONE);

  // The low byte is launched in the high byte's tx_done cycle so no idle bit appears inside a word
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    tx_data    = word_reg[7:0];
    unique case (state)
      S_DUMP_IDLE:  if (Start) next_state = (Word_count == '0) ? S_DUMP_DONE : S_DUMP_ADDR;
      S_DUMP_ADDR:  next_state = S_DUMP_WAIT1;
      S_DUMP_WAIT1: next_state = S_DUMP_LATCH;
      S_DUMP_LATCH: next_state = S_DUMP_SEND_HI;
      S_DUMP_SEND_HI: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = word_reg[15:8];
        end else if (tx_done) begin
          tx_start   = 1'b1;
          next_state = S_DUMP_SEND_LO;
        end
      end
      S_DUMP_SEND_LO: if (tx_done) next_state = (word_next < word_count_reg) ? S_DUMP_ADDR : S_DUMP_DONE;
      S_DUMP_DONE:  next_state = S_DUMP_IDLE;
      default:      next_state = S_DUMP_IDLE;
    endcase
  end

  // addr_reg tracks base + word_index; its natural ADDR_W-bit overflow gives the wrap to 0
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state          <= S_DUMP_IDLE;
      addr_reg       <= '0;
      word_index     <= '0;
      word_count_reg <= '0;
      word_reg       <= '0;
    end else begin
      state <= next_state;
      if (state == S_DUMP_IDLE && Start) begin
        word_count_reg <= Word_count;
        word_index     <= '0;
        if (Word_count != '0) addr_reg <= Base_address;
      end
      if (state == S_DUMP_LATCH) word_reg <= SRAM_read_data;
      if (state == S_DUMP_SEND_LO && tx_done) begin
        word_index <= word_next;
        if (word_next < word_count_reg) addr_reg <= addr_reg + ADDR_W'(1);
      end
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .UART_TX_O (UART_TX_O),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

endmodule
